// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile: dataflow modes, default
// operand/result widths and the signed clamp helper used by every PE.
package sa_pkg;

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

  localparam int IN_DATA_WIDTH_DEF  = 8;
  localparam int OUT_DATA_WIDTH_DEF = 32;

  // Widest result the clamp helper supports; callers sign-extend into it.
  localparam int SAT_MAX_W = 64;

  function automatic logic signed [SAT_MAX_W:0] sat_clip(
    input logic signed [SAT_MAX_W:0] value,
    input int                        width
  );
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one = (SAT_MAX_W + 1)'(1);
    hi  = (one <<< (width - 1)) - one;
    lo  = ~hi;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/pe_dual_mode_if.sv
// Port bundle of one dual-mode PE: configuration, west/north operand inputs
// and the registered east/south outputs that feed the neighbouring PEs.
interface pe_dual_mode_if
  import sa_pkg::*;
#(
  parameter int IN_W  = IN_DATA_WIDTH_DEF,
  parameter int OUT_W = OUT_DATA_WIDTH_DEF
);

  logic                    mode;
  logic                    cfg_load;
  logic signed [IN_W-1:0]  in_west;
  logic                    in_west_valid;
  logic signed [IN_W-1:0]  in_north_weight;
  logic                    in_north_weight_valid;
  logic                    weight_swap;
  logic signed [OUT_W-1:0] in_north_psum;
  logic                    in_north_psum_valid;
  logic                    drain;

  logic signed [IN_W-1:0]  out_east;
  logic                    out_east_valid;
  logic signed [IN_W-1:0]  out_south_weight;
  logic                    out_south_weight_valid;
  logic signed [OUT_W-1:0] out_south_psum;
  logic                    out_south_psum_valid;
  logic                    sat_flag;

  modport master (
    output mode, cfg_load, in_west, in_west_valid, in_north_weight,
           in_north_weight_valid, weight_swap, in_north_psum,
           in_north_psum_valid, drain,
    input  out_east, out_east_valid, out_south_weight, out_south_weight_valid,
           out_south_psum, out_south_psum_valid, sat_flag
  );

  modport slave (
    input  mode, cfg_load, in_west, in_west_valid, in_north_weight,
           in_north_weight_valid, weight_swap, in_north_psum,
           in_north_psum_valid, drain,
    output out_east, out_east_valid, out_south_weight, out_south_weight_valid,
           out_south_psum, out_south_psum_valid, sat_flag
  );

endinterface

// File: rtl/pe_mac_sat.sv
// Combinational signed multiply-add: result = a*b + addend, either clamped to
// the signed OUT_W range (with an overflow flag) or wrapped.
module pe_mac_sat
  import sa_pkg::*;
#(
  parameter int IN_W     = IN_DATA_WIDTH_DEF,
  parameter int OUT_W    = OUT_DATA_WIDTH_DEF,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic signed [OUT_W-1:0] addend,
  output logic signed [OUT_W-1:0] result,
  output logic                    ovf
);

  logic signed [2*IN_W-1:0]  product;
  logic signed [OUT_W:0]     sum;
  logic signed [SAT_MAX_W:0] sum_w;
  logic signed [SAT_MAX_W:0] clipped;

  // NOTE: every variable is assigned on every path, so no latch is inferred.
  always_comb begin
    product = a * b;
    sum     = (OUT_W + 1)'(product) + (OUT_W + 1)'(addend);
    sum_w   = (SAT_MAX_W + 1)'(sum);
    clipped = sat_clip(sum_w, OUT_W);
    if (SATURATE != 0) begin
      result = clipped[OUT_W-1:0];
      ovf    = (clipped != sum_w);
    end else begin
      result = sum[OUT_W-1:0];
      ovf    = 1'b0;
    end
  end

endmodule

// File: rtl/pe_dual_mode.sv
// Systolic PE with run-time selectable weight-stationary (double-buffered
// weight) or output-stationary (local accumulator + drain chain) dataflow.
module pe_dual_mode
  import sa_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = IN_DATA_WIDTH_DEF,
  parameter int OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF,
  parameter int SATURATE       = 1
) (
  input logic           clk,
  input logic           rstn,
  pe_dual_mode_if.slave io
);

  localparam int IW = IN_DATA_WIDTH;
  localparam int OW = OUT_DATA_WIDTH;

  mode_e                mode_q, mode_d;
  logic signed [IW-1:0] shadow_w, shadow_d;
  logic signed [IW-1:0] active_w, active_d;
  logic signed [OW-1:0] acc, acc_d;
  logic                 sat_q, sat_d;
  logic signed [OW-1:0] psum_q, psum_d;
  logic                 psum_vld_q, psum_vld_d;
  logic signed [IW-1:0] east_q, south_w_q;
  logic                 east_vld_q, south_w_vld_q;

  logic signed [IW-1:0] mac_b;
  logic signed [OW-1:0] mac_add;
  logic signed [OW-1:0] mac_res;
  logic                 mac_ovf;
  logic                 os_fire;

  assign os_fire = io.in_west_valid & io.in_north_weight_valid;

  // One MAC serves both dataflows; a drain starts the accumulator from the
  // coinciding product so that operand is not lost.
  always_comb begin
    if (mode_q == MODE_WS) begin
      mac_b   = active_w;
      mac_add = io.in_north_psum_valid ? io.in_north_psum : '0;
    end else begin
      mac_b   = io.in_north_weight;
      mac_add = io.drain ? '0 : acc;
    end
  end

  pe_mac_sat #(
    .IN_W     (IW),
    .OUT_W    (OW),
    .SATURATE (SATURATE)
  ) u_mac (
    .a      (io.in_west),
    .b      (mac_b),
    .addend (mac_add),
    .result (mac_res),
    .ovf    (mac_ovf)
  );

  always_comb begin
    mode_d     = mode_q;
    shadow_d   = shadow_w;
    active_d   = active_w;
    acc_d      = acc;
    sat_d      = sat_q;
    psum_d     = io.in_north_psum;
    psum_vld_d = io.in_north_psum_valid;

    case (mode_q)
      MODE_WS: begin
        if (io.in_north_weight_valid) shadow_d = io.in_north_weight;
        if (io.weight_swap)           active_d = shadow_w;
        if (io.in_west_valid) begin
          psum_d     = mac_res;
          psum_vld_d = 1'b1;
          sat_d      = sat_q | mac_ovf;
        end
      end
      MODE_OS: begin
        if (os_fire) begin
          acc_d = mac_res;
          sat_d = sat_q | mac_ovf;
        end
        // Own accumulator wins over any upstream word arriving with drain.
        if (io.drain) begin
          psum_d     = acc;
          psum_vld_d = 1'b1;
          if (!os_fire) acc_d = '0;
        end
      end
      default: ;
    endcase

    if (io.cfg_load) begin
      mode_d = mode_e'(io.mode);
      if (mode_e'(io.mode) != mode_q) acc_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q        <= MODE_WS;
      shadow_w      <= '0;
      active_w      <= '0;
      acc           <= '0;
      sat_q         <= 1'b0;
      psum_q        <= '0;
      psum_vld_q    <= 1'b0;
      east_q        <= '0;
      east_vld_q    <= 1'b0;
      south_w_q     <= '0;
      south_w_vld_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      shadow_w      <= shadow_d;
      active_w      <= active_d;
      acc           <= acc_d;
      sat_q         <= sat_d;
      psum_q        <= psum_d;
      psum_vld_q    <= psum_vld_d;
      east_q        <= io.in_west;
      east_vld_q    <= io.in_west_valid;
      south_w_q     <= io.in_north_weight;
      south_w_vld_q <= io.in_north_weight_valid;
    end
  end

  assign io.out_east               = east_q;
  assign io.out_east_valid         = east_vld_q;
  assign io.out_south_weight       = south_w_q;
  assign io.out_south_weight_valid = south_w_vld_q;
  assign io.out_south_psum         = psum_q;
  assign io.out_south_psum_valid   = psum_vld_q;
  assign io.sat_flag               = sat_q;

endmodule

// File: tb/tb_pe_dual_mode.sv
// Scoreboard bench for pe_dual_mode: a 32-bit saturating PE for dataflow tests
// plus 16-bit saturating and wrapping PEs for the overflow cases.
module tb_pe_dual_mode;
  import sa_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic cfg; logic md;
    logic signed [7:0] w; logic wv;
    logic signed [7:0] nw; logic nwv;
    logic swap;
    logic signed [31:0] ps; logic psv;
    logic drn;
    logic signed [31:0] exp_ps; logic exp_v;
  } stim_t;

  typedef struct {
    int idx;
    logic signed [31:0] ps; logic vld;
    logic signed [7:0] east; logic east_v;
    logic signed [7:0] sw; logic sw_v;
  } exp_t;

  typedef struct {
    logic cfg; logic md;
    logic signed [7:0] w; logic signed [7:0] nw; logic mac; logic drn;
    logic signed [15:0] exp_sat; logic signed [15:0] exp_wrap;
    logic exp_v; logic exp_flag;
  } sat_row_t;

  typedef struct {
    int idx;
    logic signed [15:0] sat_ps; logic signed [15:0] wrap_ps;
    logic vld; logic flag;
  } sat_exp_t;

  exp_t     sb_q[$];
  sat_exp_t sat_sb_q[$];

  pe_dual_mode_if #(.IN_W(8), .OUT_W(32)) bus ();
  pe_dual_mode_if #(.IN_W(8), .OUT_W(16)) bus16s ();
  pe_dual_mode_if #(.IN_W(8), .OUT_W(16)) bus16w ();

  pe_dual_mode #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(32), .SATURATE(1)) u_dut (
    .clk (clk), .rstn (rstn), .io (bus.slave)
  );
  pe_dual_mode #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(16), .SATURATE(1)) u_sat (
    .clk (clk), .rstn (rstn), .io (bus16s.slave)
  );
  pe_dual_mode #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(16), .SATURATE(0)) u_wrap (
    .clk (clk), .rstn (rstn), .io (bus16w.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cfg_load = 0; bus.mode = 0; bus.in_west = '0; bus.in_west_valid = 0;
    bus.in_north_weight = '0; bus.in_north_weight_valid = 0; bus.weight_swap = 0;
    bus.in_north_psum = '0; bus.in_north_psum_valid = 0; bus.drain = 0;
    bus16s.cfg_load = 0; bus16s.mode = 0; bus16s.in_west = '0; bus16s.in_west_valid = 0;
    bus16s.in_north_weight = '0; bus16s.in_north_weight_valid = 0; bus16s.weight_swap = 0;
    bus16s.in_north_psum = '0; bus16s.in_north_psum_valid = 0; bus16s.drain = 0;
    bus16w.cfg_load = 0; bus16w.mode = 0; bus16w.in_west = '0; bus16w.in_west_valid = 0;
    bus16w.in_north_weight = '0; bus16w.in_north_weight_valid = 0; bus16w.weight_swap = 0;
    bus16w.in_north_psum = '0; bus16w.in_north_psum_valid = 0; bus16w.drain = 0;
  endtask

  task automatic apply(input stim_t s);
    bus.cfg_load = s.cfg; bus.mode = s.md;
    bus.in_west = s.w; bus.in_west_valid = s.wv;
    bus.in_north_weight = s.nw; bus.in_north_weight_valid = s.nwv;
    bus.weight_swap = s.swap;
    bus.in_north_psum = s.ps; bus.in_north_psum_valid = s.psv;
    bus.drain = s.drn;
  endtask

  task automatic apply16(input sat_row_t r);
    bus16s.cfg_load = r.cfg; bus16s.mode = r.md;
    bus16s.in_west = r.w; bus16s.in_west_valid = r.mac;
    bus16s.in_north_weight = r.nw; bus16s.in_north_weight_valid = r.mac;
    bus16s.drain = r.drn;
    bus16w.cfg_load = r.cfg; bus16w.mode = r.md;
    bus16w.in_west = r.w; bus16w.in_west_valid = r.mac;
    bus16w.in_north_weight = r.nw; bus16w.in_north_weight_valid = r.mac;
    bus16w.drain = r.drn;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    bus.in_west = 8'sd5; bus.in_west_valid = 1'b1;
    bus.in_north_psum = 32'sd7; bus.in_north_psum_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.out_south_psum, bus.out_south_psum_valid, bus.out_east, bus.out_east_valid,
         bus.out_south_weight, bus.out_south_weight_valid, bus.sat_flag} !== 52'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got psum=%0d vld=%0b east=%0d/%0b flag=%0b, want all 0",
               bus.out_south_psum, bus.out_south_psum_valid, bus.out_east,
               bus.out_east_valid, bus.sat_flag);
    end
    n_cmp++;
    if ({bus16s.out_south_psum, bus16s.sat_flag, bus16w.out_south_psum, bus16w.sat_flag} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_16bit: got sat=%0d/%0b wrap=%0d/%0b, want 0/0 0/0",
               bus16s.out_south_psum, bus16s.sat_flag, bus16w.out_south_psum, bus16w.sat_flag);
    end
    idle();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_ws_basic();
    stim_t tbl[3] = '{
      '{0,0, 0,0,  3,1, 0,  0,0, 0,  0,0},
      '{0,0, 0,0,  0,0, 1,  0,0, 0,  0,0},
      '{0,0, 5,1,  0,0, 0, 10,1, 0, 25,1}
    };
    exp_t e;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb_q.push_back('{i, tbl[i].exp_ps, tbl[i].exp_v, tbl[i].w, tbl[i].wv, tbl[i].nw, tbl[i].nwv});
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.out_south_psum !== e.ps || bus.out_south_psum_valid !== e.vld) begin
        n_err++;
        $display("FAIL ws_basic[%0d] psum: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_south_psum, bus.out_south_psum_valid, e.ps, e.vld);
      end
      n_cmp++;
      if ({bus.out_east, bus.out_east_valid, bus.out_south_weight, bus.out_south_weight_valid}
          !== {e.east, e.east_v, e.sw, e.sw_v}) begin
        n_err++;
        $display("FAIL ws_basic[%0d] fwd: got east=%0d/%0b sw=%0d/%0b want %0d/%0b %0d/%0b", e.idx,
                 bus.out_east, bus.out_east_valid, bus.out_south_weight, bus.out_south_weight_valid,
                 e.east, e.east_v, e.sw, e.sw_v);
      end
    end
    idle();
  endtask

  task automatic test_ws_double_buffer();
    stim_t tbl[10] = '{
      '{0,0,  0,0,  2,1, 0,    0,0, 0,    0,0},
      '{0,0,  0,0,  0,0, 1,    0,0, 0,    0,0},
      '{0,0,  7,1, -4,1, 0,    0,0, 0,   14,1},
      '{0,0,  7,1,  0,0, 0,    0,0, 0,   14,1},
      '{0,0,  7,1,  9,1, 1,    0,0, 0,   14,1},
      '{0,0,  7,1,  0,0, 0,    0,0, 0,  -28,1},
      '{0,0,  7,1,  0,0, 1,    0,0, 0,  -28,1},
      '{0,0,  7,1,  0,0, 0,    0,0, 0,   63,1},
      '{0,0, -3,1,  0,0, 0, -100,1, 0, -127,1},
      '{0,0,  2,1,  0,0, 0,  555,0, 0,   18,1}
    };
    exp_t e;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb_q.push_back('{i, tbl[i].exp_ps, tbl[i].exp_v, tbl[i].w, tbl[i].wv, tbl[i].nw, tbl[i].nwv});
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.out_south_psum !== e.ps || bus.out_south_psum_valid !== e.vld) begin
        n_err++;
        $display("FAIL ws_dbuf[%0d] psum: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_south_psum, bus.out_south_psum_valid, e.ps, e.vld);
      end
      n_cmp++;
      if ({bus.out_south_weight, bus.out_south_weight_valid} !== {e.sw, e.sw_v}) begin
        n_err++;
        $display("FAIL ws_dbuf[%0d] weight_fwd: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_south_weight, bus.out_south_weight_valid, e.sw, e.sw_v);
      end
    end
    idle();
  endtask

  task automatic test_pass_through();
    stim_t tbl[7] = '{
      '{0,0, 0,0, 0,0, 0, 32'h0000DEAD,1, 0, 32'h0000DEAD,1},
      '{0,0, 9,0, 0,0, 0,           77,0, 0,           77,0},
      '{1,1, 0,0, 0,0, 0,            0,0, 0,            0,0},
      '{0,0, 0,0, 0,0, 0,           42,1, 0,           42,1},
      '{0,0, 2,1, 2,1, 0,            0,0, 0,            0,0},
      '{0,0, 0,0, 0,0, 0,           99,1, 1,            4,1},
      '{0,0, 0,0, 0,0, 0,            0,0, 0,            0,0}
    };
    exp_t e;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb_q.push_back('{i, tbl[i].exp_ps, tbl[i].exp_v, tbl[i].w, tbl[i].wv, tbl[i].nw, tbl[i].nwv});
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.out_south_psum !== e.ps || bus.out_south_psum_valid !== e.vld) begin
        n_err++;
        $display("FAIL pass_through[%0d] psum: got %0h/%0b want %0h/%0b", e.idx,
                 bus.out_south_psum, bus.out_south_psum_valid, e.ps, e.vld);
      end
      n_cmp++;
      if ({bus.out_east, bus.out_east_valid} !== {e.east, e.east_v}) begin
        n_err++;
        $display("FAIL pass_through[%0d] east: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_east, bus.out_east_valid, e.east, e.east_v);
      end
    end
    idle();
  endtask

  task automatic test_os_accumulate();
    stim_t tbl[19] = '{
      '{0,0,  2,1,  3,1, 0, 0,0, 0,   0,0},
      '{0,0,  4,1, -1,1, 0, 0,0, 0,   0,0},
      '{0,0, -5,1,  5,1, 0, 0,0, 0,   0,0},
      '{0,0,  0,0,  0,0, 0, 0,0, 1, -23,1},
      '{0,0,  0,0,  0,0, 0, 0,0, 0,   0,0},
      '{0,0,  3,1,  3,1, 0, 0,0, 0,   0,0},
      '{0,0,  6,1,  2,1, 0, 0,0, 1,   9,1},
      '{0,0,  0,0,  0,0, 0, 0,0, 1,  12,1},
      '{0,0,  0,0,  0,0, 0, 0,0, 1,   0,1},
      '{0,0,  3,1,  4,1, 0, 0,0, 0,   0,0},
      '{1,0,  0,0,  0,0, 0, 0,0, 0,   0,0},
      '{1,1,  0,0,  0,0, 0, 0,0, 0,   0,0},
      '{0,0,  0,0,  0,0, 0, 0,0, 1,   0,1},
      '{0,0,  5,1,  5,0, 0, 0,0, 0,   0,0},
      '{0,0,  0,0,  0,0, 0, 0,0, 1,   0,1},
      '{0,0,  0,0, 50,1, 1, 0,0, 0,   0,0},
      '{1,0,  0,0,  0,0, 0, 0,0, 0,   0,0},
      '{0,0,  1,1,  0,0, 1, 0,0, 0,   9,1},
      '{0,0,  1,1,  0,0, 0, 0,0, 0,   9,1}
    };
    exp_t e;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb_q.push_back('{i, tbl[i].exp_ps, tbl[i].exp_v, tbl[i].w, tbl[i].wv, tbl[i].nw, tbl[i].nwv});
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.out_south_psum !== e.ps || bus.out_south_psum_valid !== e.vld) begin
        n_err++;
        $display("FAIL os_acc[%0d] psum: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_south_psum, bus.out_south_psum_valid, e.ps, e.vld);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    sat_row_t tbl[12] = '{
      '{1,1,    0,   0, 0, 0,      0,      0, 0, 0},
      '{0,0,  127, 127, 1, 0,      0,      0, 0, 0},
      '{0,0,  127, 127, 1, 0,      0,      0, 0, 0},
      '{0,0,  127,   3, 1, 0,      0,      0, 0, 0},
      '{0,0,   11,  11, 1, 0,      0,      0, 0, 0},
      '{0,0,  127, 127, 1, 0,      0,      0, 0, 1},
      '{0,0,    0,   0, 0, 1,  32767, -16647, 1, 1},
      '{0,0, -128, 127, 1, 0,      0,      0, 0, 1},
      '{0,0, -128, 127, 1, 0,      0,      0, 0, 1},
      '{0,0, -128, 127, 1, 0,      0,      0, 0, 1},
      '{0,0,    0,   0, 0, 1, -32768,  16768, 1, 1},
      '{0,0,    0,   0, 0, 0,      0,      0, 0, 1}
    };
    sat_exp_t e;
    foreach (tbl[i]) begin
      apply16(tbl[i]);
      sat_sb_q.push_back('{i, tbl[i].exp_sat, tbl[i].exp_wrap, tbl[i].exp_v, tbl[i].exp_flag});
      tick();
      e = sat_sb_q.pop_front();
      n_cmp++;
      if (bus16s.out_south_psum !== e.sat_ps || bus16s.out_south_psum_valid !== e.vld ||
          bus16s.sat_flag !== e.flag) begin
        n_err++;
        $display("FAIL sat16[%0d]: got psum=%0d vld=%0b flag=%0b want %0d/%0b/%0b", e.idx,
                 bus16s.out_south_psum, bus16s.out_south_psum_valid, bus16s.sat_flag,
                 e.sat_ps, e.vld, e.flag);
      end
      n_cmp++;
      if (bus16w.out_south_psum !== e.wrap_ps || bus16w.out_south_psum_valid !== e.vld ||
          bus16w.sat_flag !== 1'b0) begin
        n_err++;
        $display("FAIL wrap16[%0d]: got psum=%0d vld=%0b flag=%0b want %0d/%0b/0", e.idx,
                 bus16w.out_south_psum, bus16w.out_south_psum_valid, bus16w.sat_flag,
                 e.wrap_ps, e.vld);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_op();
    stim_t pre[2] = '{
      '{1,1, 0,0, 0,0, 0, 0,0, 0, 0,0},
      '{0,0, 5,1, 5,1, 0, 0,0, 0, 0,0}
    };
    stim_t post[3] = '{
      '{0,0, 5,1, 0,0, 0, 0,0, 0, 0,1},
      '{0,0, 3,1, 0,0, 1, 0,0, 0, 0,1},
      '{0,0, 3,1, 0,0, 0, 0,0, 0, 0,1}
    };
    exp_t e;
    foreach (pre[i]) begin
      apply(pre[i]);
      tick();
    end
    n_cmp++;
    if ({bus.out_east, bus.out_east_valid} !== {8'sd5, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset_pre: got east=%0d/%0b want 5/1", bus.out_east, bus.out_east_valid);
    end
    idle();
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_south_psum, bus.out_south_psum_valid, bus.out_east, bus.out_east_valid,
         bus.out_south_weight, bus.out_south_weight_valid, bus.sat_flag, bus16s.sat_flag} !== 53'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: got east=%0d/%0b sw=%0d/%0b flag=%0b flag16=%0b want all 0",
               bus.out_east, bus.out_east_valid, bus.out_south_weight,
               bus.out_south_weight_valid, bus.sat_flag, bus16s.sat_flag);
    end
    #2 rstn = 1'b1;
    tick();
    foreach (post[i]) begin
      apply(post[i]);
      sb_q.push_back('{i, post[i].exp_ps, post[i].exp_v, post[i].w, post[i].wv, post[i].nw, post[i].nwv});
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.out_south_psum !== e.ps || bus.out_south_psum_valid !== e.vld) begin
        n_err++;
        $display("FAIL mid_reset_post[%0d] psum: got %0d/%0b want %0d/%0b", e.idx,
                 bus.out_south_psum, bus.out_south_psum_valid, e.ps, e.vld);
      end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_ws_basic();
    test_ws_double_buffer();
    test_pass_through();
    test_os_accumulate();
    test_saturation();
    test_reset_mid_op();
    if (sb_q.size() != 0 || sat_sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", sb_q.size(), sat_sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
